// File: rtl/xadc_drp_pkg.sv
// rtl/xadc_drp_pkg.sv - shared DRP widths, arbiter states and XADC register addresses
package xadc_drp_pkg;

  localparam int DRP_ADDR_WIDTH_C = 7;
  localparam int DRP_DATA_WIDTH_C = 16;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } arb_state_e;

  localparam logic [DRP_ADDR_WIDTH_C-1:0] XADC_TEMP_C    = 7'h00;
  localparam logic [DRP_ADDR_WIDTH_C-1:0] XADC_VCCINT_C  = 7'h01;
  localparam logic [DRP_ADDR_WIDTH_C-1:0] XADC_VCCAUX_C  = 7'h02;
  localparam logic [DRP_ADDR_WIDTH_C-1:0] XADC_VCCBRAM_C = 7'h06;
  localparam logic [DRP_ADDR_WIDTH_C-1:0] XADC_VAUX0_C   = 7'h10;
  localparam logic [DRP_ADDR_WIDTH_C-1:0] XADC_VAUX1_C   = 7'h11;
  localparam logic [DRP_ADDR_WIDTH_C-1:0] XADC_VAUX2_C   = 7'h12;
  localparam logic [DRP_ADDR_WIDTH_C-1:0] XADC_VAUX3_C   = 7'h13;
  localparam logic [DRP_ADDR_WIDTH_C-1:0] XADC_CFG0_C    = 7'h40;
  localparam logic [DRP_ADDR_WIDTH_C-1:0] XADC_CFG1_C    = 7'h41;
  localparam logic [DRP_ADDR_WIDTH_C-1:0] XADC_CFG2_C    = 7'h42;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick: first request at or above ptr, else wrap
module rr_arbiter #(
  parameter int N_P     = 2,
  parameter int IDX_W_P = (N_P > 1) ? $clog2(N_P) : 1
) (
  input  logic [N_P-1:0]     req_i,
  input  logic [IDX_W_P-1:0] ptr_i,
  output logic [N_P-1:0]     gnt_o,
  output logic [IDX_W_P-1:0] idx_o
);

  logic [N_P-1:0] mask;
  logic [N_P-1:0] req_hi;
  logic [N_P-1:0] pick;

  always_comb begin
    mask = '0;
    for (int i = 0; i < N_P; i++) begin
      mask[i] = (i >= int'(ptr_i));
    end
    req_hi = req_i & mask;
    // Nothing at or above the pointer means the search wraps to bit 0.
    pick  = (|req_hi) ? req_hi : req_i;
    gnt_o = '0;
    idx_o = '0;
    for (int i = N_P - 1; i >= 0; i--) begin
      if (pick[i]) begin
        gnt_o    = '0;
        gnt_o[i] = 1'b1;
        idx_o    = IDX_W_P'(i);
      end
    end
  end

endmodule

// File: rtl/xadc_drp_arbiter.sv
// rtl/xadc_drp_arbiter.sv - round-robin sharing of one XADC DRP port, one transaction at a time
module xadc_drp_arbiter
  import xadc_drp_pkg::*;
#(
  parameter int NR_OF_REQ_P = 2,
  parameter int TIMEOUT_P   = 255
) (
  input  logic                                     dclk_i,
  input  logic                                     reset_i,
  input  logic [NR_OF_REQ_P-1:0]                   req_valid_i,
  input  logic [NR_OF_REQ_P-1:0]                   req_we_i,
  input  logic [DRP_ADDR_WIDTH_C*NR_OF_REQ_P-1:0]  req_addr_i,
  input  logic [DRP_DATA_WIDTH_C*NR_OF_REQ_P-1:0]  req_di_i,
  output logic [NR_OF_REQ_P-1:0]                   req_ready_o,
  output logic [NR_OF_REQ_P-1:0]                   rsp_valid_o,
  output logic [DRP_DATA_WIDTH_C-1:0]              rsp_data_o,
  output logic                                     rsp_err_o,
  output logic [DRP_ADDR_WIDTH_C-1:0]              daddr_o,
  output logic [DRP_DATA_WIDTH_C-1:0]              di_o,
  output logic                                     den_o,
  output logic                                     dwe_o,
  input  logic [DRP_DATA_WIDTH_C-1:0]              do_i,
  input  logic                                     drdy_i,
  output logic                                     arb_busy_o
);

  localparam int IDX_W_C = (NR_OF_REQ_P > 1) ? $clog2(NR_OF_REQ_P) : 1;
  localparam int AW_C    = DRP_ADDR_WIDTH_C;
  localparam int DW_C    = DRP_DATA_WIDTH_C;
  localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT_P);

  arb_state_e               state_q, state_d;
  logic [IDX_W_C-1:0]       ptr_q, ptr_d;
  logic [NR_OF_REQ_P-1:0]   owner_q, owner_d;
  logic [AW_C-1:0]          daddr_q, daddr_d;
  logic [DW_C-1:0]          di_q, di_d;
  logic [15:0]              cnt_q, cnt_d, cnt_inc;
  logic [NR_OF_REQ_P-1:0]   ready_q, ready_d;
  logic                     den_q, den_d;
  logic                     dwe_q, dwe_d;
  logic [NR_OF_REQ_P-1:0]   rsp_valid_q, rsp_valid_d;
  logic [DW_C-1:0]          rsp_data_q, rsp_data_d;
  logic                     rsp_err_q, rsp_err_d;

  logic [NR_OF_REQ_P-1:0]   gnt;
  logic [IDX_W_C-1:0]       gnt_idx;
  logic [AW_C-1:0]          addr_arr [NR_OF_REQ_P];
  logic [DW_C-1:0]          di_arr   [NR_OF_REQ_P];

  for (genvar g = 0; g < NR_OF_REQ_P; g++) begin : g_unpack
    assign addr_arr[g] = req_addr_i[g*AW_C +: AW_C];
    assign di_arr[g]   = req_di_i[g*DW_C +: DW_C];
  end

  rr_arbiter #(
    .N_P     (NR_OF_REQ_P),
    .IDX_W_P (IDX_W_C)
  ) u_rr_arbiter (
    .req_i (req_valid_i),
    .ptr_i (ptr_q),
    .gnt_o (gnt),
    .idx_o (gnt_idx)
  );

  assign cnt_inc = cnt_q + 16'd1;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    daddr_d     = daddr_q;
    di_d        = di_q;
    cnt_d       = cnt_q;
    ready_d     = '0;
    den_d       = 1'b0;
    dwe_d       = 1'b0;
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    unique case (state_q)
      IDLE: begin
        if (|req_valid_i) begin
          state_d = ISSUE;
          owner_d = gnt;
          daddr_d = addr_arr[gnt_idx];
          di_d    = di_arr[gnt_idx];
          ready_d = gnt;
          den_d   = 1'b1;
          dwe_d   = req_we_i[gnt_idx];
          if (int'(gnt_idx) == NR_OF_REQ_P - 1) begin
            ptr_d = '0;
          end else begin
            ptr_d = gnt_idx + 1'b1;
          end
        end
      end
      ISSUE: begin
        state_d = WAIT;
        cnt_d   = '0;
      end
      WAIT: begin
        cnt_d = cnt_inc;
        // DRDY wins over a timeout landing on the same edge.
        if (drdy_i) begin
          state_d     = IDLE;
          rsp_valid_d = owner_q;
          rsp_data_d  = do_i;
          rsp_err_d   = 1'b0;
        end else if (cnt_inc == TIMEOUT_C) begin
          state_d     = IDLE;
          rsp_valid_d = owner_q;
          rsp_data_d  = '0;
          rsp_err_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge dclk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      owner_q     <= '0;
      daddr_q     <= '0;
      di_q        <= '0;
      cnt_q       <= '0;
      ready_q     <= '0;
      den_q       <= 1'b0;
      dwe_q       <= 1'b0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      daddr_q     <= daddr_d;
      di_q        <= di_d;
      cnt_q       <= cnt_d;
      ready_q     <= ready_d;
      den_q       <= den_d;
      dwe_q       <= dwe_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign req_ready_o = ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;
  assign rsp_err_o   = rsp_err_q;
  assign daddr_o     = daddr_q;
  assign di_o        = di_q;
  assign den_o       = den_q;
  assign dwe_o       = dwe_q;
  assign arb_busy_o  = (state_q != IDLE);

endmodule

// File: tb/tb_xadc_drp_arbiter.sv
// tb/tb_xadc_drp_arbiter.sv - scoreboard bench for xadc_drp_arbiter with a behavioural XADC
module tb_xadc_drp_arbiter;

  localparam int NREQ = 2;
  localparam int TO   = 8;

  typedef struct {
    int          req;
    logic        we;
    logic [6:0]  addr;
    logic [15:0] di;
    int          lat;
    logic [15:0] exp_data;
    logic        exp_err;
    int          exp_lat;
  } txn_t;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid, req_we;
  logic [7*NREQ-1:0] req_addr;
  logic [16*NREQ-1:0] req_di;
  logic [NREQ-1:0]   req_ready_o, rsp_valid_o;
  logic [15:0]       rsp_data_o, di_o, do_m;
  logic              rsp_err_o, den_o, dwe_o, arb_busy_o;
  logic [6:0]        daddr_o;
  logic              drdy_m, stale;
  logic [63:0]       outs;

  int   checks = 0;
  int   failures = 0;
  txn_t exp_q[$];
  txn_t cur;
  int   gseq[$];
  int   gcount[NREQ];
  int   rsp_count = 0;
  int   cyc = 0;
  int   den_cyc = 0;
  bit   outstanding = 0;
  int   model_last;
  logic [15:0] mem [128];
  txn_t tb_tx [NREQ][8];
  int   tcnt[NREQ];
  int   hd[NREQ];

  always #5 clk = ~clk;

  assign outs = {17'd0, req_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o, daddr_o, di_o, den_o, dwe_o, arb_busy_o};

  xadc_drp_arbiter #(.NR_OF_REQ_P(NREQ), .TIMEOUT_P(TO)) dut (
    .dclk_i      (clk),
    .reset_i     (rst),
    .req_valid_i (req_valid),
    .req_we_i    (req_we),
    .req_addr_i  (req_addr),
    .req_di_i    (req_di),
    .req_ready_o (req_ready_o),
    .rsp_valid_o (rsp_valid_o),
    .rsp_data_o  (rsp_data_o),
    .rsp_err_o   (rsp_err_o),
    .daddr_o     (daddr_o),
    .di_o        (di_o),
    .den_o       (den_o),
    .dwe_o       (dwe_o),
    .do_i        (do_m),
    .drdy_i      (drdy_m | stale),
    .arb_busy_o  (arb_busy_o)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Expected outcome from the rules: DRDY within TO cycles succeeds, otherwise timeout.
  function automatic txn_t make_txn(input int req, input logic we, input logic [6:0] addr,
                                    input logic [15:0] di, input int lat);
    txn_t t;
    t.req = req; t.we = we; t.addr = addr; t.di = di; t.lat = lat;
    if (lat <= TO) begin
      t.exp_err  = 1'b0;
      t.exp_data = we ? ~di : mem[addr];
      t.exp_lat  = 1 + lat;
    end else begin
      t.exp_err  = 1'b1;
      t.exp_data = 16'h0000;
      t.exp_lat  = 1 + TO;
    end
    return t;
  endfunction

  initial begin : xadc_model
    int l;
    bit abort;
    logic [6:0] a;
    logic w;
    logic [15:0] d;
    drdy_m = 1'b0;
    do_m   = 16'h0;
    forever begin
      @(negedge clk);
      drdy_m = 1'b0;
      do_m   = 16'($urandom);
      if (!rst && den_o && exp_q.size() > 0) begin
        l = exp_q[0].lat; a = daddr_o; w = dwe_o; d = di_o;
        if (l <= TO) begin
          abort = 1'b0;
          for (int k = 0; k < l; k++) begin
            @(negedge clk);
            if (rst) abort = 1'b1;
          end
          if (!abort) begin
            drdy_m = 1'b1;
            do_m   = w ? ~d : mem[a];
          end
        end
      end
    end
  end

  initial begin : monitor
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        outstanding = 1'b0;
      end else begin
        for (int r = 0; r < NREQ; r++) begin
          if (req_ready_o[r]) begin
            gcount[r]++;
            gseq.push_back(r);
          end
        end
        if (den_o) begin
          chk("den_while_outstanding", 64'(outstanding), 0);
          if (exp_q.size() == 0) begin
            chk("den_unexpected", 1, 0);
          end else begin
            cur = exp_q[0];
            chk("grant_onehot", 64'(req_ready_o), 64'(1 << cur.req));
            chk("daddr", 64'(daddr_o), 64'(cur.addr));
            chk("dwe", 64'(dwe_o), 64'(cur.we));
            if (cur.we) chk("di", 64'(di_o), 64'(cur.di));
            chk("busy_in_issue", 64'(arb_busy_o), 1);
            outstanding = 1'b1;
            den_cyc = cyc;
          end
        end else if (req_ready_o != '0) begin
          chk("ready_without_den", 64'(req_ready_o), 0);
        end
        if (rsp_valid_o != '0) begin
          if (!outstanding) begin
            chk("rsp_unexpected", 64'(rsp_valid_o), 0);
          end else begin
            chk("rsp_owner", 64'(rsp_valid_o), 64'(1 << cur.req));
            chk("rsp_data", 64'(rsp_data_o), 64'(cur.exp_data));
            chk("rsp_err", 64'(rsp_err_o), 64'(cur.exp_err));
            chk("rsp_latency", 64'(cyc - den_cyc), 64'(cur.exp_lat));
            chk("busy_at_rsp", 64'(arb_busy_o), 0);
            void'(exp_q.pop_front());
            outstanding = 1'b0;
            rsp_count++;
          end
        end
      end
    end
  end

  function automatic bit pending();
    bit p = 1'b0;
    for (int i = 0; i < NREQ; i++) if (hd[i] < tcnt[i]) p = 1'b1;
    return p;
  endfunction

  task automatic clear_batch();
    for (int i = 0; i < NREQ; i++) tcnt[i] = 0;
  endtask

  task automatic drive_heads();
    for (int r = 0; r < NREQ; r++) begin
      if (hd[r] < tcnt[r]) begin
        req_valid[r]          = 1'b1;
        req_we[r]             = tb_tx[r][hd[r]].we;
        req_addr[r*7 +: 7]    = tb_tx[r][hd[r]].addr;
        req_di[r*16 +: 16]    = tb_tx[r][hd[r]].di;
      end else begin
        req_valid[r] = 1'b0;
      end
    end
  endtask

  task automatic wait_drain();
    int b = 0;
    while (exp_q.size() > 0 && b < 500) begin
      @(negedge clk);
      b++;
    end
    chk("drain_queue_empty", 64'(exp_q.size()), 0);
    repeat (2) @(negedge clk);
  endtask

  // Every requester holds its queue continuously, so the grant order is a pure rotation.
  task automatic run_batch();
    int left = 0;
    int budget = 0;
    int base, r, nl;
    bit found;
    for (int i = 0; i < NREQ; i++) begin
      hd[i] = 0;
      left += tcnt[i];
    end
    while (left > 0) begin
      found = 1'b0;
      base  = model_last;
      nl    = model_last;
      for (int o = 1; o <= NREQ; o++) begin
        r = (base + o) % NREQ;
        if (!found && hd[r] < tcnt[r]) begin
          exp_q.push_back(tb_tx[r][hd[r]]);
          hd[r]++;
          nl = r;
          left--;
          found = 1'b1;
        end
      end
      model_last = nl;
    end
    for (int i = 0; i < NREQ; i++) hd[i] = 0;
    drive_heads();
    while (pending() && budget < 3000) begin
      @(negedge clk);
      budget++;
      for (int i = 0; i < NREQ; i++) if (req_ready_o[i]) hd[i]++;
      drive_heads();
    end
    chk("batch_grant_budget", 64'(budget >= 3000), 0);
    wait_drain();
  endtask

  initial begin : watchdog
    #600000;
    failures++;
    $display("FAIL watchdog: actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin : stimulus
    int b, rc0, g1;
    txn_t tr;
    rst = 1'b1;
    req_valid = '0; req_we = '0; req_addr = '0; req_di = '0; stale = 1'b0;
    for (int i = 0; i < 128; i++) mem[i] = 16'($urandom);
    mem[0] = 16'h9A30;
    model_last = NREQ - 1;
    #3;
    chk("reset_outputs_zero", outs, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    clear_batch();
    tb_tx[0][0] = make_txn(0, 1'b0, 7'h00, 16'h0000, 4);
    tcnt[0] = 1;
    run_batch();

    clear_batch();
    tb_tx[1][0] = make_txn(1, 1'b1, 7'h40, 16'h0123, 3);
    tcnt[1] = 1;
    run_batch();

    clear_batch();
    for (int i = 0; i < 3; i++) begin
      for (int r = 0; r < NREQ; r++) begin
        tb_tx[r][i] = make_txn(r, 1'($urandom_range(0, 1)), 7'($urandom), 16'($urandom),
                               int'($urandom_range(1, TO)));
      end
      tcnt[0]++; tcnt[1]++;
    end
    gseq.delete();
    run_batch();
    chk("fair_count", 64'(gseq.size()), 6);
    for (int i = 0; i < 6; i++) chk("fair_order", 64'(gseq[i]), 64'(i % 2));

    clear_batch();
    tb_tx[0][0] = make_txn(0, 1'b0, 7'h01, 16'h0000, 100);
    tcnt[0] = 1;
    run_batch();
    rc0 = rsp_count;
    stale = 1'b1;
    @(negedge clk);
    stale = 1'b0;
    repeat (4) @(negedge clk);
    chk("late_drdy_no_rsp", 64'(rsp_count - rc0), 0);

    tr = make_txn(0, 1'b0, 7'h02, 16'h0000, 100);
    exp_q.push_back(tr);
    model_last = 0;
    req_we[0] = 1'b0; req_addr[6:0] = 7'h02; req_valid[0] = 1'b1;
    b = 0;
    while (!req_ready_o[0] && b < 50) begin
      @(negedge clk);
      b++;
    end
    chk("rst_test_granted", 64'(req_ready_o[0]), 1);
    req_valid[0] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 chk("async_reset_outputs_zero", outs, 0);
    exp_q.delete();
    outstanding = 1'b0;
    rc0 = rsp_count;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_last = NREQ - 1;
    repeat (12) @(negedge clk);
    chk("no_rsp_after_reset", 64'(rsp_count - rc0), 0);
    clear_batch();
    tb_tx[0][0] = make_txn(0, 1'b0, 7'h06, 16'h0000, 2);
    tb_tx[1][0] = make_txn(1, 1'b0, 7'h10, 16'h0000, 5);
    tcnt[0] = 1; tcnt[1] = 1;
    gseq.delete();
    run_batch();
    chk("post_reset_first_grant", 64'(gseq.size() > 0 ? gseq[0] : 99), 0);

    g1 = gcount[1];
    exp_q.push_back(make_txn(0, 1'b0, 7'h11, 16'h0000, 6));
    model_last = 0;
    req_we[0] = 1'b0; req_addr[6:0] = 7'h11; req_valid[0] = 1'b1;
    b = 0;
    while (!req_ready_o[0] && b < 50) begin
      @(negedge clk);
      b++;
    end
    req_valid[0] = 1'b0;
    @(negedge clk);
    req_we[1] = 1'b1; req_addr[13:7] = 7'h41; req_di[31:16] = 16'hBEEF; req_valid[1] = 1'b1;
    repeat (2) @(negedge clk);
    req_valid[1] = 1'b0;
    wait_drain();
    repeat (4) @(negedge clk);
    chk("withdrawn_never_granted", 64'(gcount[1] - g1), 0);
    rc0 = rsp_count;
    stale = 1'b1;
    @(negedge clk);
    stale = 1'b0;
    repeat (4) @(negedge clk);
    chk("idle_drdy_no_rsp", 64'(rsp_count - rc0), 0);

    for (int n = 0; n < 8; n++) begin
      clear_batch();
      for (int r = 0; r < NREQ; r++) begin
        tcnt[r] = int'($urandom_range(0, 3));
        for (int i = 0; i < tcnt[r]; i++) begin
          tb_tx[r][i] = make_txn(r, 1'($urandom_range(0, 1)), 7'($urandom), 16'($urandom),
                                 int'($urandom_range(1, TO + 3)));
        end
      end
      run_batch();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
